// File: rtl/sound_mailbox_pkg.sv
// Shared types and constants for the 68k <-> 6502 sound mailbox controller.
package sound_mailbox_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } nmi_state_e;

  localparam int STAT_CMD_PEND  = 7;
  localparam int STAT_RESP_FULL = 6;
  localparam int STAT_CMD_OVR   = 5;
  localparam int STAT_RESP_OVR  = 4;

  // One bit per active-low strobe; used for both sampled levels and fall events.
  typedef struct packed {
    logic main_wr;
    logic main_rd;
    logic wr68k;
    logic rd68k;
    logic siord;
  } strobe_evt_t;

  localparam strobe_evt_t STROBE_IDLE = 5'b11111;

  function automatic strobe_evt_t strobe_fall(input strobe_evt_t prev, input strobe_evt_t cur);
    return strobe_evt_t'(prev & ~cur);
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous command FIFO; push is accepted while full only when a pop happens in the same cycle.
module mailbox_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array: written at the tail, no reset needed for data.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sound_mailbox_ctrl.sv
// Command/response mailbox between the main 68k CPU and the 6502 sound CPU,
// including the NMI sequencer that prods the 6502 until the command FIFO drains.
module sound_mailbox_ctrl
  import sound_mailbox_pkg::*;
#(
  parameter int CMD_DEPTH  = 4,
  parameter int NMI_CYCLES = 8
) (
  input  logic       clock_15,
  input  logic       rst_l,
  input  logic       main_wr_l,
  input  logic       main_rd_l,
  input  logic [7:0] main_din,
  output logic [7:0] main_dout,
  output logic       main_irq,
  input  logic       WR68k_l,
  input  logic       RD68k_l,
  input  logic       SIORD_l,
  input  logic [7:0] sd_in,
  output logic [7:0] sd_out,
  output logic       sd_oe,
  output logic       sndnmi
);

  localparam int         CW       = $clog2(CMD_DEPTH) + 1;
  localparam logic [7:0] CNT_LOAD = 8'(NMI_CYCLES - 1);

  strobe_evt_t      prev_r;
  strobe_evt_t      cur_s;
  strobe_evt_t      evt_s;

  logic [7:0]       fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  logic [CW-1:0]    next_count_s;
  logic             push_s;
  logic             pop_s;
  logic             cmd_pending_s;

  logic [7:0]       resp_latch_r;
  logic             resp_full_r;
  logic             cmd_ovr_r;
  logic             resp_ovr_r;
  logic [7:0]       status_s;

  nmi_state_e       state_r;
  logic [7:0]       cnt_r;
  logic             sndnmi_r;

  assign cur_s         = {main_wr_l, main_rd_l, WR68k_l, RD68k_l, SIORD_l};
  assign evt_s         = strobe_fall(prev_r, cur_s);
  assign cmd_pending_s = ~fifo_empty_s;

  // A full FIFO still takes a byte when the 6502 pops in the same cycle.
  assign pop_s        = evt_s.rd68k & ~fifo_empty_s;
  assign push_s       = evt_s.main_wr & (~fifo_full_s | pop_s);
  assign next_count_s = fifo_count_s + CW'(push_s) - CW'(pop_s);

  mailbox_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (8)
  ) u_cmd_fifo (
    .clk   (clock_15),
    .rst_n (rst_l),
    .push  (push_s),
    .pop   (pop_s),
    .din   (main_din),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Strobe history, response latch and sticky overrun flags.
  always_ff @(posedge clock_15 or negedge rst_l) begin
    if (!rst_l) begin
      prev_r       <= STROBE_IDLE;
      resp_latch_r <= 8'h00;
      resp_full_r  <= 1'b0;
      cmd_ovr_r    <= 1'b0;
      resp_ovr_r   <= 1'b0;
    end else begin
      prev_r     <= cur_s;
      // A status read clears the flags, but an overrun landing in that cycle wins.
      cmd_ovr_r  <= (cmd_ovr_r & ~evt_s.siord) |
                    (evt_s.main_wr & fifo_full_s & ~pop_s);
      resp_ovr_r <= (resp_ovr_r & ~evt_s.siord) |
                    (evt_s.wr68k & resp_full_r & ~evt_s.main_rd);
      if (evt_s.wr68k) begin
        resp_latch_r <= sd_in;
        resp_full_r  <= 1'b1;
      end else if (evt_s.main_rd) begin
        resp_full_r  <= 1'b0;
      end else begin
        resp_full_r  <= resp_full_r;
      end
    end
  end

  assign main_dout = resp_latch_r;
  assign main_irq  = resp_full_r;

  // Status byte seen by the 6502 on SIORD.
  always_comb begin
    status_s                 = 8'h00;
    status_s[STAT_CMD_PEND]  = cmd_pending_s;
    status_s[STAT_RESP_FULL] = resp_full_r;
    status_s[STAT_CMD_OVR]   = cmd_ovr_r;
    status_s[STAT_RESP_OVR]  = resp_ovr_r;
  end

  assign sd_oe = ~RD68k_l | ~SIORD_l;

  // 6502 read mux; status takes priority when both strobes are low.
  always_comb begin
    sd_out = 8'h00;
    if (!SIORD_l) begin
      sd_out = status_s;
    end else if (!RD68k_l) begin
      sd_out = fifo_empty_s ? 8'h00 : fifo_head_s;
    end else begin
      sd_out = 8'h00;
    end
  end

  // NMI sequencer: pulse, wait for the 6502 to fetch, then gap and re-pulse while commands remain.
  always_ff @(posedge clock_15 or negedge rst_l) begin
    if (!rst_l) begin
      state_r  <= IDLE;
      cnt_r    <= 8'h00;
      sndnmi_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_pending_s) begin
            state_r  <= PULSE;
            cnt_r    <= CNT_LOAD;
            sndnmi_r <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_r == 8'h00) begin
            state_r  <= WAIT;
            sndnmi_r <= 1'b0;
          end else begin
            cnt_r    <= cnt_r - 8'h01;
          end
        end
        WAIT: begin
          if (evt_s.rd68k) begin
            state_r <= (next_count_s != CW'(0)) ? GAP : IDLE;
          end
        end
        GAP: begin
          state_r  <= PULSE;
          cnt_r    <= CNT_LOAD;
          sndnmi_r <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 8'h00;
          sndnmi_r <= 1'b0;
        end
      endcase
    end
  end

  assign sndnmi = sndnmi_r;

endmodule

// File: tb/tb_sound_mailbox_ctrl.sv
// Bench for sound_mailbox_ctrl: directed scenarios plus random strobes, all checked
// every cycle against a queue-based behavioural model of the mailbox.
module tb_sound_mailbox_ctrl;

  localparam int DEPTH = 4;
  localparam int NMI   = 8;

  logic       clock_15 = 1'b0;
  logic       rst_l;
  logic       main_wr_l, main_rd_l, WR68k_l, RD68k_l, SIORD_l;
  logic [7:0] main_din, sd_in;
  logic [7:0] main_dout, sd_out;
  logic       main_irq, sd_oe, sndnmi;

  always #5 clock_15 = ~clock_15;

  sound_mailbox_ctrl #(.CMD_DEPTH(DEPTH), .NMI_CYCLES(NMI)) dut (
    .clock_15 (clock_15),
    .rst_l    (rst_l),
    .main_wr_l(main_wr_l),
    .main_rd_l(main_rd_l),
    .main_din (main_din),
    .main_dout(main_dout),
    .main_irq (main_irq),
    .WR68k_l  (WR68k_l),
    .RD68k_l  (RD68k_l),
    .SIORD_l  (SIORD_l),
    .sd_in    (sd_in),
    .sd_out   (sd_out),
    .sd_oe    (sd_oe),
    .sndnmi   (sndnmi)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [7:0] m_q[$];
  bit         m_full, m_covr, m_rovr;
  logic [7:0] m_latch;
  int         m_hi;       // remaining high cycles of the current NMI pulse
  bit         m_ack;      // pulse finished, waiting for the 6502 to fetch
  bit         m_gap;      // one low cycle before the next pulse
  bit         p_wr, p_mrd, p_w68, p_rd, p_sio;

  int cyc = 0, nmi_rises = 0, nmi_hi_cycles = 0, first_hi = -1;
  bit last_nmi = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_full = 1'b0; m_covr = 1'b0; m_rovr = 1'b0; m_latch = 8'h00;
    m_hi = 0; m_ack = 1'b0; m_gap = 1'b0;
    p_wr = 1'b1; p_mrd = 1'b1; p_w68 = 1'b1; p_rd = 1'b1; p_sio = 1'b1;
  endtask

  task automatic model_step();
    bit e_wr, e_mrd, e_w68, e_rd, e_sio, had_cmd, was_full, pop, push;
    e_wr  = p_wr  && !main_wr_l;
    e_mrd = p_mrd && !main_rd_l;
    e_w68 = p_w68 && !WR68k_l;
    e_rd  = p_rd  && !RD68k_l;
    e_sio = p_sio && !SIORD_l;
    had_cmd  = (m_q.size() != 0);
    was_full = (m_q.size() == DEPTH);
    pop  = e_rd && had_cmd;
    push = e_wr && (!was_full || pop);
    m_covr = (m_covr && !e_sio) || (e_wr && was_full && !pop);
    m_rovr = (m_rovr && !e_sio) || (e_w68 && m_full && !e_mrd);
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(main_din);
    if (e_w68) begin
      m_latch = sd_in;
      m_full  = 1'b1;
    end else if (e_mrd) begin
      m_full  = 1'b0;
    end
    if (m_hi > 0) begin
      m_hi--;
      if (m_hi == 0) m_ack = 1'b1;
    end else if (m_ack) begin
      if (e_rd) begin
        m_ack = 1'b0;
        m_gap = (m_q.size() != 0);
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
      m_hi  = NMI;
    end else if (had_cmd) begin
      m_hi = NMI;
    end
    p_wr = main_wr_l; p_mrd = main_rd_l; p_w68 = WR68k_l; p_rd = RD68k_l; p_sio = SIORD_l;
  endtask

  // Called just after a falling edge with inputs set; checks, clocks, advances model.
  task automatic cycle();
    logic [7:0] stat, exp_sd;
    bit oe;
    #1;
    stat   = {(m_q.size() != 0), m_full, m_covr, m_rovr, 4'h0};
    oe     = !RD68k_l || !SIORD_l;
    exp_sd = !SIORD_l ? stat : ((m_q.size() != 0) ? m_q[0] : 8'h00);
    check_val("sd_oe", {7'h0, sd_oe}, {7'h0, oe});
    if (oe) check_val("sd_out", sd_out, exp_sd);
    check_val("main_dout", main_dout, m_latch);
    check_val("main_irq", {7'h0, main_irq}, {7'h0, m_full});
    check_val("sndnmi", {7'h0, sndnmi}, {7'h0, (m_hi > 0)});
    if (sndnmi && !last_nmi) nmi_rises++;
    if (sndnmi) nmi_hi_cycles++;
    if (sndnmi && first_hi < 0) first_hi = cyc;
    last_nmi = sndnmi;
    @(posedge clock_15);
    model_step();
    cyc++;
    @(negedge clock_15);
  endtask

  task automatic main_write(input logic [7:0] d, input int hold);
    main_din = d; main_wr_l = 1'b0;
    repeat (hold) cycle();
    main_wr_l = 1'b1;
    cycle();
  endtask

  task automatic resp_write(input logic [7:0] d);
    sd_in = d; WR68k_l = 1'b0; cycle();
    WR68k_l = 1'b1; cycle();
  endtask

  task automatic main_read();
    main_rd_l = 1'b0; cycle();
    main_rd_l = 1'b1; cycle();
  endtask

  task automatic status_read(input string tag, input logic [7:0] exp);
    SIORD_l = 1'b0;
    #1 check_val(tag, sd_out, exp);
    cycle();
    SIORD_l = 1'b1;
    cycle();
  endtask

  // Let the 6502 fetch each command as its NMI pulse completes, until the mailbox is quiet.
  task automatic drain(output int reads, output logic [7:0] first);
    int  budget;
    bit  done;
    reads = 0; first = 8'h00; budget = 400; done = 1'b0;
    while (!done && budget > 0) begin
      budget--;
      if (m_ack) begin
        RD68k_l = 1'b0;
        #1;
        if (reads == 0) first = sd_out;
        reads++;
        cycle();
        RD68k_l = 1'b1;
      end else begin
        cycle();
      end
      done = (m_q.size() == 0) && (m_hi == 0) && !m_ack && !m_gap;
    end
    check_val("drain_done", {7'h0, done}, 8'h01);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c0, reads;
    logic [7:0] first;

    model_reset();
    rst_l = 1'b0;
    main_wr_l = 1'b1; main_rd_l = 1'b1; WR68k_l = 1'b1; RD68k_l = 1'b1; SIORD_l = 1'b1;
    main_din = 8'h00; sd_in = 8'h00;
    #1;
    check_val("rst_dout", main_dout, 8'h00);
    check_val("rst_irq", {7'h0, main_irq}, 8'h00);
    check_val("rst_nmi", {7'h0, sndnmi}, 8'h00);
    check_val("rst_oe", {7'h0, sd_oe}, 8'h00);
    @(negedge clock_15);
    @(negedge clock_15);
    rst_l = 1'b1;
    cycle();

    // Held write strobe gives one push; pulse of NMI cycles starting two cycles later.
    first_hi = -1; nmi_hi_cycles = 0; c0 = cyc;
    main_write(8'hA5, 3);
    repeat (20) cycle();
    check_val("nmi_latency", 8'(first_hi - c0), 8'd2);
    check_val("nmi_width", 8'(nmi_hi_cycles), 8'(NMI));
    status_read("stat_pending", 8'h80);

    RD68k_l = 1'b0;
    #1;
    check_val("rd_head", sd_out, 8'hA5);
    check_val("rd_oe", {7'h0, sd_oe}, 8'h01);
    cycle();
    RD68k_l = 1'b1;
    repeat (3) cycle();
    status_read("stat_empty", 8'h00);
    repeat (12) cycle();

    // Three commands -> three pulses, read in order.
    nmi_rises = 0;
    main_write(8'h01, 1);
    main_write(8'h02, 1);
    main_write(8'h03, 1);
    drain(reads, first);
    check_val("three_reads", 8'(reads), 8'd3);
    check_val("three_first", first, 8'h01);
    check_val("three_pulses", 8'(nmi_rises), 8'd3);

    // Overflow: fifth byte dropped and cmd_ovr raised until a status read.
    for (int i = 0; i < 5; i++) main_write(8'(8'h10 + i), 1);
    status_read("stat_ovr", 8'hA0);
    status_read("stat_ovr_clr", 8'h80);
    drain(reads, first);
    check_val("ovr_reads", 8'(reads), 8'd4);
    check_val("ovr_first", first, 8'h10);

    // Response latch and overrun.
    resp_write(8'h3C);
    #1;
    check_val("resp_irq", {7'h0, main_irq}, 8'h01);
    check_val("resp_dout", main_dout, 8'h3C);
    resp_write(8'h7E);
    #1 check_val("resp_dout2", main_dout, 8'h7E);
    status_read("stat_rovr", 8'h50);
    main_read();
    #1 check_val("resp_clr", {7'h0, main_irq}, 8'h00);

    // Simultaneous main read and 6502 write: write wins, no overrun.
    resp_write(8'h11);
    sd_in = 8'h22; WR68k_l = 1'b0; main_rd_l = 1'b0;
    cycle();
    WR68k_l = 1'b1; main_rd_l = 1'b1;
    cycle();
    #1;
    check_val("simul_irq", {7'h0, main_irq}, 8'h01);
    check_val("simul_dout", main_dout, 8'h22);
    status_read("stat_simul", 8'h40);

    // Asynchronous reset in the middle of a pulse.
    main_write(8'h55, 1);
    repeat (3) cycle();
    #1 check_val("pre_rst_nmi", {7'h0, sndnmi}, 8'h01);
    rst_l = 1'b0;
    #1;
    check_val("mid_rst_nmi", {7'h0, sndnmi}, 8'h00);
    check_val("mid_rst_irq", {7'h0, main_irq}, 8'h00);
    check_val("mid_rst_dout", main_dout, 8'h00);
    check_val("mid_rst_oe", {7'h0, sd_oe}, 8'h00);
    model_reset();
    @(negedge clock_15);
    rst_l = 1'b1;
    cycle();
    status_read("stat_post_rst", 8'h00);

    // Random strobe activity, checked every cycle against the model.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 3) == 0) main_wr_l = ~main_wr_l;
      if ($urandom_range(0, 5) == 0) main_rd_l = ~main_rd_l;
      if ($urandom_range(0, 5) == 0) WR68k_l   = ~WR68k_l;
      if ($urandom_range(0, 4) == 0) RD68k_l   = ~RD68k_l;
      if ($urandom_range(0, 6) == 0) SIORD_l   = ~SIORD_l;
      main_din = 8'($urandom);
      sd_in    = 8'($urandom);
      cycle();
    end
    main_wr_l = 1'b1; main_rd_l = 1'b1; WR68k_l = 1'b1; RD68k_l = 1'b1; SIORD_l = 1'b1;
    cycle();
    drain(reads, first);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sound_mailbox_ctrl.md
Name: sound_mailbox_ctrl

Overview:
- Controls the command/response mailbox between the main 68k CPU and the 6502 sound CPU.
- Main side writes commands into a small FIFO; the block sequences sndnmi pulses to the 6502 until the FIFO is drained.
- 6502 writes status/response bytes into a single latch that raises main_irq.
- Sits beside soundAddressDecoder: it consumes WR68k_l/RD68k_l/SIORD_l, drives the SD bus on reads, and drives the 6502 NMI input.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of 2, 2..16.
- NMI_CYCLES, 8, clock_15 cycles sndnmi is held high per pulse; 1..255.

Ports:
- clock_15  in  1  system clock; all state on rising edge.
- rst_l  in  1  asynchronous active-low reset.
- main_wr_l  in  1  main CPU command-write strobe, active low, may be held multiple cycles.
- main_rd_l  in  1  main CPU response-read strobe, active low, may be held multiple cycles.
- main_din  in  8  command byte, sampled on main_wr_l event.
- main_dout  out  8  response latch contents.
- main_irq  out  1  high while response latch is full.
- WR68k_l  in  1  6502 response-write strobe from decoder, active low.
- RD68k_l  in  1  6502 command-read strobe from decoder, active low.
- SIORD_l  in  1  6502 status-read strobe from decoder, active low.
- sd_in  in  8  6502 data bus (write data).
- sd_out  out  8  read data to 6502 data bus.
- sd_oe  out  1  high when sd_out must drive the bus.
- sndnmi  out  1  NMI to 6502, active high.

Behaviour:
- Every strobe is edge-detected. An event is the cycle where prev=1 and cur=0. Prev registers reset to 1, so a strobe held low out of reset produces no event. A strobe held low for N cycles yields exactly one event.
- Command FIFO:
  - main_wr event and not full: push main_din.
  - main_wr event and full, with no simultaneous pop: drop the byte, set cmd_ovr (sticky).
  - RD68k event and not empty: pop. RD68k event on empty: no pop, sd_out=8'h00.
  - Push and pop in the same cycle are both performed. A push while full with a simultaneous pop is accepted.
  - Pointers wrap modulo CMD_DEPTH; count is $clog2(CMD_DEPTH)+1 bits.
- Response latch:
  - WR68k event: latch sd_in and set resp_full. If resp_full was already 1 and there is no simultaneous main_rd event, also set resp_ovr (sticky).
  - main_rd event: clear resp_full. If a WR68k event occurs in the same cycle, the write wins: new data is latched and resp_full stays 1, with no overrun.
  - main_irq = resp_full; main_dout = latch (registered).
- 6502 read path (combinational from registers):
  - sd_oe = ~RD68k_l | ~SIORD_l.
  - RD68k_l low: sd_out = FIFO head (head before the pop).
  - SIORD_l low: sd_out = {cmd_pending, resp_full, cmd_ovr, resp_ovr, 4'b0}, where cmd_pending = FIFO not empty.
  - Both low: the status byte wins.
  - SIORD event clears cmd_ovr/resp_ovr on the following cycle. An overrun set in that same cycle survives.
- NMI sequencer FSM:
  - IDLE: if cmd_pending, go to PULSE and load cnt=NMI_CYCLES-1.
  - PULSE: sndnmi=1. Decrement cnt; at 0 go to WAIT.
  - WAIT: sndnmi=0. On an RD68k event, evaluate the FIFO count after that cycle's push/pop (next state): nonempty goes to GAP, empty goes to IDLE.
  - GAP: one cycle with sndnmi=0 to guarantee a rising edge, then PULSE.
  - Pushes during PULSE/WAIT do not restart the pulse.
  - Latency: a push at cycle t makes sndnmi high from t+2 (push registered at t+1, FSM in PULSE at t+2).
- Reset (async, rst_l=0): FIFO empty, pointers 0, all flags 0, latch 8'h00, main_dout 8'h00, main_irq 0, sndnmi 0, FSM IDLE. sd_oe follows the strobes; with strobes high it is 0. Reset mid-pulse drops sndnmi immediately.

Decomposition:
- sound_mailbox_pkg holds the FSM enum (IDLE, PULSE, WAIT, GAP), the status bit-position constants (STAT_CMD_PEND=7, STAT_RESP_FULL=6, STAT_CMD_OVR=5, STAT_RESP_OVR=4) and the strobe-event helper typedef.
- One sub-module, mailbox_fifo: synchronous parameterised FIFO with push/pop/full/empty/count. The remainder stays in the top.

Test Plan:
- Reset, then main_wr_l low 3 cycles with main_din=8'hA5 -> exactly one push; sndnmi high for 8 cycles starting 2 cycles after the event; status read returns 8'h80.
- 6502 RD68k read -> sd_out=8'hA5, sd_oe=1; FIFO empty; FSM returns to IDLE; status 8'h00.
- Push 8'h01, 8'h02, 8'h03, then one RD68k read -> returns 8'h01; GAP then a second NMI pulse; repeat until empty, 3 pulses total.
- Push 5 bytes with CMD_DEPTH=4 -> 5th dropped; status 8'hA0; after the status read the next status is 8'h80.
- WR68k with sd_in=8'h3C -> main_irq=1, main_dout=8'h3C. A second WR68k with 8'h7E before a main read -> resp_ovr set, main_dout=8'h7E. main_rd event -> main_irq=0.
- main_rd and WR68k events in the same cycle -> main_irq stays 1, new byte latched, resp_ovr stays 0. Assert rst_l low during PULSE -> sndnmi=0 asynchronously, all outputs at reset values.
